// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants for the PS/2 scan-code receiver: prefix bytes, FSM encodings
// and the frame validity check.
package ps2_scancode_rx_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Odd parity over data+parity and a high stop bit.
  function automatic logic frame_ok(input logic [7:0] data, input logic par,
                                    input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 line.
// The filtered output only follows the input after FILTER_LEN stable cycles.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Idle-high bus: all line state resets to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_out = filt_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frame decode, E0/F0 prefix folding and held-key
// tracking for the pitch-select logic.
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic [7:0] keyout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic clk_f, data_f;
  logic fall;

  logic          clk_prev_q, clk_prev_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_break_q, key_break_d;
  logic          key_ext_q, key_ext_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    keyout_q, keyout_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .line_in(ps2clk), .line_out(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .line_in(ps2data), .line_out(data_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  always_comb begin
    clk_prev_d  = clk_f;
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = '0;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_break_d = key_break_q;
    key_ext_d   = key_ext_q;
    frame_err_d = 1'b0;
    keyout_d    = keyout_q;

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          bitcnt_d = 3'd0;
          if (!data_f) state_d = ST_DATA;
        end
        ST_DATA: begin
          shift_d  = {data_f, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_f;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (!frame_ok(shift_q, par_q, data_f)) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end else if (shift_q == PS2_PREFIX_EXT) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == PS2_PREFIX_BRK) begin
            brk_pend_d = 1'b1;
          end else begin
            key_valid_d = 1'b1;
            key_code_d  = shift_q;
            key_break_d = brk_pend_q;
            key_ext_d   = ext_pend_q;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
            // Only a release of the currently held key clears keyout.
            if (!brk_pend_q) begin
              keyout_d = shift_q;
            end else if (shift_q == keyout_q) begin
              keyout_d = 8'h00;
            end
          end
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d     = ST_IDLE;
        bitcnt_d    = 3'd0;
        frame_err_d = 1'b1;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_code_q  <= 8'h00;
      key_valid_q <= 1'b0;
      key_break_q <= 1'b0;
      key_ext_q   <= 1'b0;
      frame_err_q <= 1'b0;
      keyout_q    <= 8'h00;
    end else begin
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_break_q <= key_break_d;
      key_ext_q   <= key_ext_d;
      frame_err_q <= frame_err_d;
      keyout_q    <= keyout_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_break = key_break_q;
  assign key_ext   = key_ext_q;
  assign frame_err = frame_err_q;
  assign keyout    = keyout_q;

endmodule
